// File: rtl/inst_mem_loader.sv
// inst_mem_loader
// ---------------
// Write-side partner of the instruction fetch unit. It takes a valid/ready
// byte stream and packs it into the 16-bit instruction memory. A load can
// start at any byte address. Byte address A selects word A[13:1] and lane A[0].
// Lane 0 is bits [7:0] and lane 1 is bits [15:8], so fetch reads the
// bytes back in the order they were streamed.
//
// Ports:
//   clk              system clock
//   rst_async        asynchronous, active-high reset
//   start            one-cycle load request, only looked at while idle
//   start_byte_addr  first destination byte address
//   byte_count       number of bytes to load (0..2^BYTE_ADDR_W)
//   byte_in          stream data
//   byte_valid       stream data valid
//   byte_ready       loader accepts a byte this cycle
//   busy             load in progress (low only while idle)
//   done             one-cycle pulse once the final write has issued
//   mem_we           instruction memory write strobe
//   mem_waddr        word address
//   mem_wdata        write data (lanes with a clear enable are don't-care)
//   mem_wbe          byte enables, bit0 = lane [7:0], bit1 = lane [15:8]
//   checksum         modulo-256 sum of accepted bytes
//                    (present only with INST_MEM_LOADER_CHECKSUM_EN)
//
// Build option: define INST_MEM_LOADER_CHECKSUM_EN to add the checksum output.

module inst_mem_loader #(
  parameter int BYTE_ADDR_W = 14
) (
  input  logic                   clk,
  input  logic                   rst_async,
  input  logic                   start,
  input  logic [BYTE_ADDR_W-1:0] start_byte_addr,
  input  logic [BYTE_ADDR_W:0]   byte_count,
  input  logic [7:0]             byte_in,
  input  logic                   byte_valid,
  output logic                   byte_ready,
  output logic                   busy,
  output logic                   done,
  output logic                   mem_we,
  output logic [BYTE_ADDR_W-2:0] mem_waddr,
  output logic [15:0]            mem_wdata,
  output logic [1:0]             mem_wbe
`ifdef INST_MEM_LOADER_CHECKSUM_EN
  ,
  output logic [7:0]             checksum
`endif
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2,
    FINISH  = 2'd3
  } state_t;

  localparam logic [BYTE_ADDR_W-1:0] ADDR_ONE = 1;
  localparam logic [BYTE_ADDR_W:0]   CNT_ONE  = 1;
  localparam logic [BYTE_ADDR_W:0]   CNT_ZERO = '0;

  state_t                 state;
  logic [BYTE_ADDR_W-1:0] addr;
  logic [BYTE_ADDR_W:0]   remaining;
  logic [15:0]            word_buf;
  logic [1:0]             be;

  logic                   accept;
  logic                   lane;
  logic                   last_byte;
  logic [15:0]            buf_next;
  logic [1:0]             be_next;

  // Handshake and the word buffer as it looks once the current byte is merged.
  // The write registers load from buf_next/be_next directly, so a lane-1 or
  // final byte costs no extra cycle before its write.
  always_comb begin
    accept    = byte_valid && byte_ready && (state == COLLECT);
    lane      = addr[0];
    last_byte = (remaining == CNT_ONE);
    buf_next  = word_buf;
    be_next   = be;
    if (lane) begin
      buf_next[15:8] = byte_in;
      be_next[1]     = 1'b1;
    end else begin
      buf_next[7:0]  = byte_in;
      be_next[0]     = 1'b1;
    end
  end

  // Loader FSM. Every output is a register that is updated on the transition
  // into the state where it applies. This keeps byte_ready, mem_* and done
  // glitch-free. The async reset clears them at once, which aborts a load and
  // drops any partial word.
  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      state      <= IDLE;
      addr       <= '0;
      remaining  <= '0;
      word_buf   <= '0;
      be         <= '0;
      byte_ready <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      mem_we     <= 1'b0;
      mem_waddr  <= '0;
      mem_wdata  <= '0;
      mem_wbe    <= '0;
`ifdef INST_MEM_LOADER_CHECKSUM_EN
      checksum   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            addr      <= start_byte_addr;
            remaining <= byte_count;
            word_buf  <= '0;
            be        <= '0;
            busy      <= 1'b1;
`ifdef INST_MEM_LOADER_CHECKSUM_EN
            checksum  <= '0;
`endif
            if (byte_count == CNT_ZERO) begin
              state <= FINISH;
              done  <= 1'b1;
            end else begin
              state      <= COLLECT;
              byte_ready <= 1'b1;
            end
          end
        end

        // A lane-1 byte completes its word. The last byte flushes a partial word.
        COLLECT: begin
          if (accept) begin
            addr      <= addr + ADDR_ONE;
            remaining <= remaining - CNT_ONE;
`ifdef INST_MEM_LOADER_CHECKSUM_EN
            checksum  <= checksum + byte_in;
`endif
            if (lane || last_byte) begin
              state      <= WRITE;
              byte_ready <= 1'b0;
              mem_we     <= 1'b1;
              mem_waddr  <= addr[BYTE_ADDR_W-1:1];
              mem_wdata  <= buf_next;
              mem_wbe    <= be_next;
              word_buf   <= '0;
              be         <= '0;
            end else begin
              word_buf <= buf_next;
              be       <= be_next;
            end
          end
        end

        WRITE: begin
          mem_we  <= 1'b0;
          mem_wbe <= '0;
          if (remaining == CNT_ZERO) begin
            state <= FINISH;
            done  <= 1'b1;
          end else begin
            state      <= COLLECT;
            byte_ready <= 1'b1;
          end
        end

        FINISH: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_mem_loader.sv
// Self-checking bench for inst_mem_loader.
// A table of load descriptors drives the stream. A packing model pushes the
// expected memory writes into a queue, and a monitor pops and compares them
// whenever mem_we is seen. Hand-written sequences cover zero-length loads
// and reset in the middle of a load.

module tb_inst_mem_loader;

  typedef struct {
    logic [13:0] addr;
    logic [14:0] count;
    logic [31:0] bytes;      // byte i lives in bits [8*i +: 8]
    int          exp_writes;
    logic [7:0]  valid_pat;  // byte_valid per cycle, bit 0 first, repeats
    bit          mid_start;  // pulse a stray start while the load runs
  } vec_t;

  typedef struct {
    logic [12:0] waddr;
    logic [15:0] wdata;
    logic [1:0]  wbe;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_async = 1'b1;
  logic        start = 1'b0;
  logic [13:0] start_byte_addr = '0;
  logic [14:0] byte_count = '0;
  logic [7:0]  byte_in = '0;
  logic        byte_valid = 1'b0;
  logic        byte_ready;
  logic        busy;
  logic        done;
  logic        mem_we;
  logic [12:0] mem_waddr;
  logic [15:0] mem_wdata;
  logic [1:0]  mem_wbe;
`ifdef INST_MEM_LOADER_CHECKSUM_EN
  logic [7:0]  checksum;
`endif

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [15:0] mon_mask;
  int          total = 0;
  int          bad = 0;
  int          wr_cnt = 0;
  int          done_cnt = 0;
  bit          ready_seen = 1'b0;
  logic [7:0]  exp_sum = '0;
  vec_t        vecs[6];

  inst_mem_loader dut (
    .clk             (clk),
    .rst_async       (rst_async),
    .start           (start),
    .start_byte_addr (start_byte_addr),
    .byte_count      (byte_count),
    .byte_in         (byte_in),
    .byte_valid      (byte_valid),
    .byte_ready      (byte_ready),
    .busy            (busy),
    .done            (done),
    .mem_we          (mem_we),
    .mem_waddr       (mem_waddr),
    .mem_wdata       (mem_wdata),
    .mem_wbe         (mem_wbe)
`ifdef INST_MEM_LOADER_CHECKSUM_EN
    ,
    .checksum        (checksum)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Monitor on the falling edge. Only lanes whose enable is set are compared,
  // because the other lanes of mem_wdata are don't-care.
  always @(negedge clk) begin
    if (!rst_async) begin
      if (byte_ready) ready_seen = 1'b1;
      if (done) done_cnt++;
      if (mem_we) begin
        wr_cnt++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_write: got waddr=0x%0h wdata=0x%0h wbe=%b, required no write",
                   mem_waddr, mem_wdata, mem_wbe);
        end else begin
          mon_e    = exp_q.pop_front();
          mon_mask = {{8{mon_e.wbe[1]}}, {8{mon_e.wbe[0]}}};
          checkOutput("waddr", 32'(mem_waddr), 32'(mon_e.waddr));
          checkOutput("wbe", 32'(mem_wbe), 32'(mon_e.wbe));
          checkOutput("wdata", 32'(mem_wdata & mon_mask), 32'(mon_e.wdata & mon_mask));
        end
      end
    end
  end

  // Packing model. Each byte goes into lane a[0]. A word is flushed after a
  // lane-1 byte or after the last byte. Addresses wrap at 14 bits.
  task automatic pushModel(input vec_t v);
    logic [13:0] a;
    logic [15:0] w;
    logic [1:0]  e;
    exp_t        x;
    a = v.addr;
    w = '0;
    e = '0;
    for (int i = 0; i < int'(v.count); i++) begin
      w[a[0]*8 +: 8] = v.bytes[i*8 +: 8];
      e[a[0]] = 1'b1;
      if (a[0] || i == int'(v.count) - 1) begin
        x.waddr = a[13:1];
        x.wdata = w;
        x.wbe   = e;
        exp_q.push_back(x);
        w = '0;
        e = '0;
      end
      a = a + 14'd1;
    end
  endtask

  task automatic applyStimulus(input vec_t v, input bit use_model);
    int idx;
    int cyc;
    bit hs;
    if (use_model) pushModel(v);
    wr_cnt     = 0;
    done_cnt   = 0;
    ready_seen = 1'b0;
    exp_sum    = '0;
    for (int i = 0; i < int'(v.count); i++) exp_sum = exp_sum + v.bytes[i*8 +: 8];
    @(posedge clk); #1;
    start           = 1'b1;
    start_byte_addr = v.addr;
    byte_count      = v.count;
    @(posedge clk); #1;
    start = 1'b0;
    idx = 0;
    cyc = 0;
    while (idx < int'(v.count) && cyc < 200) begin
      byte_valid = v.valid_pat[cyc % 8];
      byte_in    = v.bytes[idx*8 +: 8];
      if (v.mid_start && cyc == 1) begin
        start           = 1'b1;
        start_byte_addr = 14'h1234;
        byte_count      = 15'd7;
      end
      hs = byte_valid && byte_ready;
      @(posedge clk); #1;
      start = 1'b0;
      if (hs) idx++;
      cyc++;
    end
    byte_valid = 1'b0;
    checkOutput("bytes_consumed", 32'(idx), 32'(v.count));
    cyc = 0;
    while (done_cnt == 0 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    repeat (3) @(posedge clk);
    #1;
    checkOutput("done_pulses", 32'(done_cnt), 32'd1);
    checkOutput("write_count", 32'(wr_cnt), 32'(v.exp_writes));
    checkOutput("pending_writes", 32'(exp_q.size()), 32'd0);
    checkOutput("busy_after", 32'(busy), 32'd0);
    checkOutput("ready_seen", 32'(ready_seen), 32'(v.count != 0));
`ifdef INST_MEM_LOADER_CHECKSUM_EN
    checkOutput("checksum", 32'(checksum), 32'(exp_sum));
`endif
  endtask

  initial begin
    vec_t v;
    bit   hs;
    int   cyc;
    vecs[0] = '{addr: 14'h0000, count: 15'd4, bytes: 32'h44332211, exp_writes: 2, valid_pat: 8'hFF, mid_start: 1'b0};
    vecs[1] = '{addr: 14'h0003, count: 15'd3, bytes: 32'h00CCBBAA, exp_writes: 2, valid_pat: 8'hFF, mid_start: 1'b0};
    vecs[2] = '{addr: 14'h0010, count: 15'd1, bytes: 32'h0000005A, exp_writes: 1, valid_pat: 8'hFF, mid_start: 1'b0};
    vecs[3] = '{addr: 14'h3FFF, count: 15'd2, bytes: 32'h00008877, exp_writes: 2, valid_pat: 8'h99, mid_start: 1'b1};
    vecs[4] = '{addr: 14'h0005, count: 15'd4, bytes: 32'h04030201, exp_writes: 3, valid_pat: 8'h55, mid_start: 1'b0};
    vecs[5] = '{addr: 14'h0000, count: 15'd2, bytes: 32'h000002FF, exp_writes: 1, valid_pat: 8'hFF, mid_start: 1'b0};

    // Reset values while reset is held.
    #12;
    checkOutput("rst_byte_ready", 32'(byte_ready), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
    checkOutput("rst_mem_wbe", 32'(mem_wbe), 32'd0);
    checkOutput("rst_mem_waddr", 32'(mem_waddr), 32'd0);
    checkOutput("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    @(posedge clk); #1;
    rst_async = 1'b0;

    for (int i = 0; i < 6; i++) applyStimulus(vecs[i], 1'b1);

    // Zero-length load: done in the cycle after start, no write, byte_ready
    // never raised.
    wr_cnt = 0; done_cnt = 0; ready_seen = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; start_byte_addr = 14'h0100; byte_count = 15'd0;
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("zero_done", 32'(done), 32'd1);
    checkOutput("zero_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    checkOutput("zero_done_end", 32'(done), 32'd0);
    checkOutput("zero_busy_end", 32'(busy), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("zero_writes", 32'(wr_cnt), 32'd0);
    checkOutput("zero_ready_seen", 32'(ready_seen), 32'd0);
    checkOutput("zero_done_pulses", 32'(done_cnt), 32'd1);

    // Reset mid-load. The first of four bytes is taken, then the second,
    // which puts a write in flight. Reset lands between edges in that cycle.
    wr_cnt = 0; done_cnt = 0;
    @(posedge clk); #1;
    start = 1'b1; start_byte_addr = 14'h0000; byte_count = 15'd4;
    @(posedge clk); #1;
    start = 1'b0;
    byte_valid = 1'b1;
    byte_in = 8'h11;
    cyc = 0;
    hs = 1'b0;
    while (!hs && cyc < 20) begin
      hs = byte_ready;
      @(posedge clk); #1;
      cyc++;
    end
    byte_in = 8'h22;
    @(posedge clk); #1;
    byte_valid = 1'b0;
    rst_async = 1'b1;
    #1;
    checkOutput("abort_mem_we", 32'(mem_we), 32'd0);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_byte_ready", 32'(byte_ready), 32'd0);
    @(posedge clk); #1;
    rst_async = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("abort_done_pulses", 32'(done_cnt), 32'd0);
    checkOutput("abort_writes", 32'(wr_cnt), 32'd0);
    exp_q.delete();

    // Clean two-byte load after the abort, expectation written by hand.
    v = '{addr: 14'h0000, count: 15'd2, bytes: 32'h0000BEEF, exp_writes: 1, valid_pat: 8'hFF, mid_start: 1'b0};
    exp_q.push_back('{waddr: 13'h0000, wdata: 16'hBEEF, wbe: 2'b11});
    applyStimulus(v, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
